// File: rtl/regfile_scoreboard.sv
// Architectural register file with a saturating pending-write counter per register,
// N combinational read ports, optional writeback-to-read bypass and a sticky writeback error.
module regfile_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS   = 2,
  parameter int PEND_WIDTH     = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_valid,
  output logic                                 source_not_ready,
  input  logic                                 alloc_en,
  input  logic [REG_ADDR_WIDTH-1:0]            alloc_addr,
  output logic                                 alloc_stall,
  input  logic                                 wb_en,
  input  logic [REG_ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]                wb_data,
  output logic                                 wb_err
);

  localparam logic [PEND_WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0]     CNT_ONE = PEND_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH:0]   NREG    = (REG_ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [PEND_WIDTH-1:0] r_cnt  [NUM_REGS];
  logic                  r_wb_err;

  logic                  w_alloc_req;
  logic                  w_alloc_stall;
  logic                  w_alloc_acc;
  logic                  w_wb_act;
  logic                  w_wb_err_set;
  logic [NUM_REGS-1:0]   w_inc;
  logic [NUM_REGS-1:0]   w_dec;

  logic [REG_ADDR_WIDTH-1:0]          w_a;
  logic                               w_hit;
  logic                               w_zero;
  logic [NUM_RD_PORTS-1:0]            w_rd_valid;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] w_rd_data;
  logic                               w_snr;

  // Addresses beyond NUM_REGS behave like x0 (no storage behind them).
  function automatic logic in_range(input logic [REG_ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NREG;
  endfunction

  assign w_alloc_req   = alloc_en & (alloc_addr != '0) & in_range(alloc_addr);
  assign w_alloc_stall = w_alloc_req & (r_cnt[alloc_addr] == CNT_MAX)
                       & ~(wb_en & (wb_addr == alloc_addr));
  assign w_alloc_acc   = w_alloc_req & ~w_alloc_stall;
  assign w_wb_act      = wb_en & (wb_addr != '0) & in_range(wb_addr);
  assign w_wb_err_set  = w_wb_act & (r_cnt[wb_addr] == '0)
                       & ~(w_alloc_acc & (alloc_addr == wb_addr));

  // A writeback only decrements when something is pending, counting a same-cycle allocation.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = w_alloc_acc & (alloc_addr == REG_ADDR_WIDTH'(r));
      w_dec[r] = w_wb_act & (wb_addr == REG_ADDR_WIDTH'(r)) & ((r_cnt[r] != '0) | w_inc[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r]  <= '0;
        r_regs[r] <= '0;
      end
      r_wb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] != w_dec[r])
          r_cnt[r] <= w_inc[r] ? r_cnt[r] + 1'b1 : r_cnt[r] - 1'b1;
      end
      if (w_wb_act)
        r_regs[wb_addr] <= wb_data;
      if (w_wb_err_set)
        r_wb_err <= 1'b1;
    end
  end

  // Reads look at the counters before this cycle's allocation takes effect.
  always_comb begin
    w_a        = '0;
    w_hit      = 1'b0;
    w_zero     = 1'b0;
    w_rd_valid = '0;
    w_rd_data  = '0;
    w_snr      = 1'b0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      w_a    = rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      w_zero = (w_a == '0) | ~in_range(w_a);
      w_hit  = (BYPASS != 0) & wb_en & (wb_addr == w_a) & (r_cnt[w_a] == CNT_ONE);
      w_rd_valid[i] = (r_cnt[w_a] == '0) | w_hit | w_zero;
      w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_zero ? '0 : (w_hit ? wb_data : r_regs[w_a]);
      w_snr = w_snr | (rd_en[i] & ~w_rd_valid[i]);
    end
  end

  assign rd_data          = w_rd_data;
  assign rd_valid         = w_rd_valid;
  assign source_not_ready = w_snr;
  assign alloc_stall      = w_alloc_stall;
  assign wb_err           = r_wb_err;

endmodule
